// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FLUSH  = 2'd2
  } pipe_ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          SB_CNT_W  = 2;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-writer counters with two source read ports and an rd read port
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_en_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic             dec_en_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  input  logic [IDX_W-1:0] rs1_idx_i,
  input  logic [IDX_W-1:0] rs2_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rs1_cnt_o,
  output logic [CNT_W-1:0] rs2_cnt_o,
  output logic [CNT_W-1:0] rd_cnt_o
);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;

  // x0 is never tracked; a decrement of an empty counter is dropped
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_hit[i] = (i != 0) && inc_en_i && (inc_idx_i == IDX_W'(i));
      dec_hit[i] = (i != 0) && dec_en_i && (dec_idx_i == IDX_W'(i)) && (cnt_q[i] != '0);
      cnt_d[i]   = cnt_q[i];
      if (inc_hit[i] && !dec_hit[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_hit[i] && !inc_hit[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (dec_en_i && (dec_idx_i != '0)) begin
        assert (cnt_q[dec_idx_i] != '0);
      end
    end
  end

  assign rs1_cnt_o = cnt_q[rs1_idx_i];
  assign rs2_cnt_o = cnt_q[rs2_idx_i];
  assign rd_cnt_o  = cnt_q[rd_idx_i];

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/freeze sequencer for the 5-stage pipe
// Optional write-through bypass of source hazards: PIPE_CTRL_WB_BYPASS_EN
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = SB_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IF_stall,
  input  logic       MA_stall,
  input  logic       br_taken,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_writes_rd,
  input  logic       wb_we,
  input  logic [4:0] wb_rd,
  output logic       pc_hold,
  output logic       if_id_hold,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pipe_freeze,
  output logic       issue,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_ctrl_state_t state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic             rs1_byp, rs2_byp, hazard;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_en_i  (issue && id_writes_rd),
    .inc_idx_i (id_rd),
    .dec_en_i  (wb_we),
    .dec_idx_i (wb_rd),
    .rs1_idx_i (id_rs1),
    .rs2_idx_i (id_rs2),
    .rd_idx_i  (id_rd),
    .rs1_cnt_o (rs1_cnt),
    .rs2_cnt_o (rs2_cnt),
    .rd_cnt_o  (rd_cnt)
  );

`ifdef PIPE_CTRL_WB_BYPASS_EN
  // the last outstanding writer is committing right now and the regfile writes through
  assign rs1_byp = wb_we && (wb_rd == id_rs1) && (rs1_cnt == CNT_W'(1));
  assign rs2_byp = wb_we && (wb_rd == id_rs2) && (rs2_cnt == CNT_W'(1));
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign hazard = id_valid &&
                  ((id_uses_rs1 && (id_rs1 != '0) && (rs1_cnt != '0) && !rs1_byp) ||
                   (id_uses_rs2 && (id_rs2 != '0) && (rs2_cnt != '0) && !rs2_byp) ||
                   (id_writes_rd && (id_rd != '0) && (rd_cnt == CNT_MAX)));

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    issue        = 1'b0;
    case (state_q)
      RUN: begin
        if (MA_stall) begin
          pipe_freeze = 1'b1;
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          state_d     = FREEZE;
          if (br_taken) flush_pend_d = 1'b1;
        end else if (br_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hazard) begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_hold    = IF_stall;
          if_id_hold = IF_stall;
          issue      = id_valid;
        end
      end
      FREEZE: begin
        pipe_freeze = 1'b1;
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        if (br_taken) flush_pend_d = 1'b1;
        if (!MA_stall) state_d = (flush_pend_q || br_taken) ? FLUSH : RUN;
      end
      FLUSH: begin
        // a new memory stall outranks the flush; the pending flag replays it afterwards
        if (MA_stall) begin
          pipe_freeze = 1'b1;
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          state_d     = FREEZE;
        end else begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a counting reference model
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, IF_stall, MA_stall, br_taken, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, id_writes_rd, wb_we;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, issue;
  logic [1:0] state;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .IF_stall(IF_stall), .MA_stall(MA_stall), .br_taken(br_taken),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_writes_rd(id_writes_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .issue(issue), .state(state)
  );

  always #5 clk = ~clk;

  localparam int MAXW = (1 << SB_CNT_W) - 1;
`ifdef PIPE_CTRL_WB_BYPASS_EN
  localparam int RAW_STALLS = 2;
`else
  localparam int RAW_STALLS = 3;
`endif

  int total = 0;
  int passed = 0;

  int               cnt_m [32];
  pipe_ctrl_state_t mode_m;
  bit               pend_m;

  logic       o_issue, o_bubble, o_flush, o_pchold, o_freeze;
  logic [1:0] o_state;
  logic [7:0] o_pack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit busy(input int r);
    if (r == 0 || cnt_m[r] == 0) return 1'b0;
`ifdef PIPE_CTRL_WB_BYPASS_EN
    if (cnt_m[r] == 1 && wb_we && int'(wb_rd) == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // One clock: predict outputs from the rules, compare mid-cycle, then advance the model.
  // Expected vector bits: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, issue}
  task automatic step(input string tag);
    bit               hz, inc, dec;
    bit [5:0]         e;
    pipe_ctrl_state_t nmode;
    bit               npend;
    hz = id_valid && ((id_uses_rs1 && busy(int'(id_rs1))) ||
                      (id_uses_rs2 && busy(int'(id_rs2))) ||
                      (id_writes_rd && id_rd != 0 && cnt_m[id_rd] == MAXW));
    nmode = mode_m;
    npend = pend_m;
    if (mode_m == RUN) begin
      if (MA_stall) begin
        e = 6'b110010; nmode = FREEZE;
        if (br_taken) npend = 1'b1;
      end else if (br_taken) e = 6'b001100;
      else if (hz) e = 6'b110100;
      else e = {IF_stall, IF_stall, 3'b000, id_valid};
    end else if (mode_m == FREEZE) begin
      e = 6'b110010;
      if (br_taken) npend = 1'b1;
      if (!MA_stall) nmode = npend ? FLUSH : RUN;
    end else begin
      if (MA_stall) begin
        e = 6'b110010; nmode = FREEZE;
      end else begin
        e = 6'b001100; npend = 1'b0; nmode = RUN;
      end
    end
    @(negedge clk);
    o_issue = issue; o_bubble = id_ex_bubble; o_flush = if_id_flush;
    o_pchold = pc_hold; o_freeze = pipe_freeze; o_state = state;
    o_pack = {state, pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, issue};
    if (!rst) chk(tag, {24'd0, o_pack}, {24'd0, mode_m, e});
    @(posedge clk);
    if (rst) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      mode_m = RUN;
      pend_m = 1'b0;
    end else begin
      inc = e[0] && id_writes_rd && id_rd != 0;
      dec = wb_we && wb_rd != 0 && cnt_m[wb_rd] > 0;
      if (inc) cnt_m[id_rd]++;
      if (dec) cnt_m[wb_rd]--;
      mode_m = nmode;
      pend_m = npend;
    end
    #1;
  endtask

  task automatic idle();
    IF_stall = 0; MA_stall = 0; br_taken = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_writes_rd = 0; wb_we = 0; wb_rd = 0;
  endtask

  task automatic dec_set(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] d, input logic w);
    id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    id_rd = d; id_writes_rd = w;
  endtask

  initial begin
    int nb, iss_at, r;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    mode_m = RUN;
    pend_m = 1'b0;
    idle();
    rst = 1;
    #1;
    step("rst");
    rst = 0;
    step("reset_state");
    chk("reset_outs", {24'd0, o_pack}, 32'd0);

    // RAW dependence on x5 with writeback three cycles after the producer issues
    dec_set(1, 0, 0, 0, 0, 5, 1);
    step("raw_prod");
    chk("raw_prod_issue", {31'd0, o_issue}, 32'd1);
    dec_set(1, 5, 1, 1, 1, 6, 1);
    nb = 0;
    iss_at = -1;
    for (int k = 0; k < 8 && iss_at < 0; k++) begin
      wb_we = (k == 2);
      wb_rd = 5;
      step("raw_cons");
      if (o_bubble) nb++;
      if (o_issue) iss_at = k;
    end
    chk("raw_bubbles", nb, RAW_STALLS);
    chk("raw_issue_at", iss_at, RAW_STALLS);
    idle();

    // taken branch beats a concurrent hazard and the squashed writer leaves no count
    dec_set(1, 0, 0, 0, 0, 9, 1);
    step("br_prod");
    dec_set(1, 9, 1, 0, 0, 10, 1);
    br_taken = 1;
    step("br_flush");
    chk("br_if_id_flush", {31'd0, o_flush}, 32'd1);
    chk("br_bubble", {31'd0, o_bubble}, 32'd1);
    chk("br_pc_hold", {31'd0, o_pchold}, 32'd0);
    chk("br_issue", {31'd0, o_issue}, 32'd0);
    br_taken = 0;
    dec_set(1, 10, 1, 0, 0, 0, 0);
    step("br_after");
    chk("br_no_inc", {31'd0, o_issue}, 32'd1);
    idle();

    // branch arriving during a memory freeze is replayed as one flush cycle
    MA_stall = 1;
    for (int k = 0; k < 4; k++) begin
      br_taken = (k == 1);
      step("dfr_frz");
      chk("dfr_freeze", {31'd0, o_freeze}, 32'd1);
    end
    br_taken = 0;
    MA_stall = 0;
    step("dfr_exit");
    step("dfr_flush");
    chk("dfr_flush_out", {31'd0, o_flush}, 32'd1);
    chk("dfr_flush_state", {30'd0, o_state}, {30'd0, FLUSH});
    step("dfr_run");
    chk("dfr_run_state", {30'd0, o_state}, {30'd0, RUN});

    // three outstanding writers of x7 saturate its counter
    dec_set(1, 0, 0, 0, 0, 7, 1);
    for (int k = 0; k < 3; k++) begin
      step("sat_fill");
      chk("sat_fill_issue", {31'd0, o_issue}, 32'd1);
    end
    step("sat_block0");
    chk("sat_block0", {31'd0, o_bubble}, 32'd1);
    step("sat_block1");
    chk("sat_block1", {31'd0, o_issue}, 32'd0);
    wb_we = 1;
    wb_rd = 7;
    step("sat_wb");
    chk("sat_wb_cycle", {31'd0, o_issue}, 32'd0);
    wb_we = 0;
    step("sat_release");
    chk("sat_release", {31'd0, o_issue}, 32'd1);
    idle();

    // increment and decrement of x3 in one cycle leaves its count at one
    dec_set(1, 0, 0, 0, 0, 3, 1);
    step("sim_first");
    wb_we = 1;
    wb_rd = 3;
    step("sim_both");
    chk("sim_both_issue", {31'd0, o_issue}, 32'd1);
    wb_we = 0;
    dec_set(1, 3, 1, 0, 0, 0, 0);
    step("sim_still1");
    chk("sim_still_busy", {31'd0, o_bubble}, 32'd1);
    wb_we = 1;
    step("sim_wb");
    wb_we = 0;
    step("sim_clear");
    chk("sim_clear", {31'd0, o_issue}, 32'd1);
    idle();

    // x0 is never a hazard; reset during a freeze drops everything
    dec_set(1, 0, 0, 0, 0, 0, 1);
    step("x0_write");
    dec_set(1, 0, 1, 0, 1, 0, 1);
    step("x0_read");
    chk("x0_issue", {31'd0, o_issue}, 32'd1);
    chk("x0_bubble", {31'd0, o_bubble}, 32'd0);
    idle();
    MA_stall = 1;
    br_taken = 1;
    step("rst_frz0");
    br_taken = 0;
    step("rst_frz1");
    rst = 1;
    step("rst_mid");
    rst = 0;
    idle();
    step("rst_after");
    chk("rst_after_outs", {24'd0, o_pack}, 32'd0);
    dec_set(1, 7, 1, 6, 1, 7, 1);
    step("rst_cleared");
    chk("rst_cnt_cleared", {31'd0, o_issue}, 32'd1);
    chk("rst_no_flush", {30'd0, o_state}, {30'd0, RUN});
    idle();

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      IF_stall = ($urandom_range(0, 9) == 0);
      MA_stall = ($urandom_range(0, 11) == 0) || (MA_stall && $urandom_range(0, 1) == 1);
      br_taken = ($urandom_range(0, 9) == 0);
      dec_set($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      r = $urandom_range(1, 7);
      wb_we = (cnt_m[r] > 0) && ($urandom_range(0, 2) == 0);
      wb_rd = 5'(r);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage rv32i pipeline. It keeps a register-write scoreboard and stalls decode on RAW hazards, because decode reads the regfile directly and there is no forwarding path. It squashes wrong-path instructions on a taken branch, freezes the pipe on memory stalls, and defers a flush that arrives during a freeze. It drives the hold, flush and bubble controls of the PC, IF/ID and ID/EX registers, replacing per-stage ad-hoc stall logic.

Parameters:
NUM_REGS, 32, architectural registers tracked (x0 never tracked)
CNT_W, 2, width of each per-register pending-writer counter (max in-flight writers = 2^CNT_W-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IF_stall  in  1  I-cache miss; fetch not valid this cycle
MA_stall  in  1  D-cache busy; whole pipeline must freeze
br_taken  in  1  EX resolved a taken branch/jump this cycle
id_valid  in  1  IF/ID holds a real instruction
id_rs1  in  5  decode source 1 index
id_rs2  in  5  decode source 2 index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  5  decode destination index
id_writes_rd  in  1  instruction writes rd
wb_we  in  1  WB commits a register write (one cycle per instruction)
wb_rd  in  5  WB destination index
pc_hold  out  1  PC keeps its value
if_id_hold  out  1  IF/ID keeps its contents
if_id_flush  out  1  IF/ID loads NOP (0x00000013)
id_ex_bubble  out  1  ID/EX loads NOP with zero control word
pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold
issue  out  1  decode instruction advances to EX this cycle
state  out  2  current FSM state (debug)

Behaviour:
- Reset: all counters 0, flush_pending 0, state RUN. Every output is 0 in the cycle after rst, except state=RUN.
- Outputs are combinational from the current state, counters and inputs. Counters, flush_pending and state update on posedge clk.
- hazard = id_valid & ((id_uses_rs1 & rs1≠0 & cnt[rs1]≠0) | (id_uses_rs2 & rs2≠0 & cnt[rs2]≠0) | (id_writes_rd & rd≠0 & cnt[rd]==max)).
- Priority, highest first: rst > freeze > flush > hazard > IF_stall.
- FSM states are RUN, FREEZE and FLUSH.
- RUN:
  - If MA_stall: go to FREEZE. Set flush_pending if br_taken.
  - Else if br_taken: if_id_flush=1, id_ex_bubble=1, stay in RUN.
  - Else if hazard: pc_hold=1, if_id_hold=1, id_ex_bubble=1.
  - Else if IF_stall: pc_hold=1, if_id_hold=1. ID still issues if id_valid.
- FREEZE: pipe_freeze=pc_hold=if_id_hold=1, issue=0. Stay while MA_stall. br_taken during FREEZE sets flush_pending. When MA_stall drops, go to FLUSH if flush_pending, else RUN.
- FLUSH (exactly 1 cycle): if_id_flush=1, id_ex_bubble=1. Clear flush_pending, then go to RUN. Any br_taken in this cycle is absorbed by the same flush.
- issue = id_valid & id_writes_rd path clear & state==RUN & !MA_stall & !br_taken & !hazard.
- Scoreboard:
  - cnt[id_rd]++ when issue & id_writes_rd & id_rd≠0.
  - cnt[wb_rd]-- when wb_we & wb_rd≠0.
  - If both hit the same register in one cycle, the net change is 0.
  - Decrement at 0 is ignored; it also raises a simulation assertion.
  - Increment at max cannot occur, because the hazard term blocks it.
- Squashed instructions never issue, so they never increment the scoreboard.
- Decode stalls during the WB cycle of its producer. The decremented count is visible on the following cycle, so the RAW stall ends the cycle after writeback.
- Reset asserted mid-stall or mid-freeze clears everything immediately; no flush is carried over.

Optional Feature:
PIPE_CTRL_WB_BYPASS_EN
- Defined: the regfile is write-through. A source hazard is ignored when cnt==1 and wb_we & wb_rd matches the source in the same cycle, saving one stall cycle per dependence.
- Undefined: conservative behaviour as above.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - pipe_ctrl_state_t enum {RUN, FREEZE, FLUSH}
  - NOP_INSTR = 32'h00000013
  - SB_CNT_W default
- Sub-module reg_scoreboard holds the counter array, increment/decrement logic and two combinational read ports plus an rd read port. pipeline_ctrl holds the FSM and output muxing.

Test Plan:
- RAW stall:
  - Stimulus: issue `addi x5` (rd=5), then `add x6,x5,x1`; wb_we/wb_rd=5 three cycles later.
  - Required: id_ex_bubble=1 for 3 cycles, second instruction issues on the 4th. With PIPE_CTRL_WB_BYPASS_EN, 2 cycles.
- Branch flush:
  - Stimulus: br_taken=1 in RUN with a hazard also present.
  - Required: if_id_flush=id_ex_bubble=1, pc_hold=0, no scoreboard increment.
- Deferred flush:
  - Stimulus: MA_stall=1 for 4 cycles, br_taken=1 in cycle 2.
  - Required: pipe_freeze=1 for all 4 cycles, then one FLUSH cycle with if_id_flush=1, then RUN.
- Counter saturation:
  - Stimulus: three `lw x7` issue back to back without writeback; a fourth instruction writes x7.
  - Required: the fourth stalls until one wb_we to rd=7 arrives.
- Simultaneous increment/decrement:
  - Stimulus: issue with rd=3 in the same cycle as wb_we/wb_rd=3, with cnt[3]=1.
  - Required: cnt[3] stays 1.
- x0 and reset:
  - Stimulus: issue rd=0 then read x0, then assert rst during FREEZE.
  - Required: no stall on x0; after rst, state=RUN, all outputs 0, counters cleared.
